// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code sequencer: prefix and
// special scan codes, FSM state encoding and the decoded event record.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERRF  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2,
        EMIT   = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

    // Bytes that carry no key identity and must never reach the consumer.
    function automatic logic is_drop_code(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERRF) || (b == SC_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_scan_ctrl.sv
// Pops the PS/2 receiver FIFO one byte at a time, folds E0/F0 prefixes into
// a single make/break key event, tracks the held key and counts presses.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_overflow,
    output logic             rx_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic [CNT_W-1:0] press_cnt,
    output logic             held,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic             err_ovf,
    input  logic             err_clr,
    output logic [1:0]       dbg_state
);

    // Handshake: evt_valid rises with a new event and holds evt_code/evt_ext/
    // evt_break stable; the event is consumed on the rising edge where
    // evt_valid and evt_ready are both 1. evt_valid never drops without that.

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             ext_f_q, ext_f_d;
    logic             brk_f_q, brk_f_d;
    key_evt_t         evt_q, evt_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             held_q, held_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic             err_ovf_q, err_ovf_d;

    logic             held_match;

    assign held_match = held_q && (byte_q == held_code_q) && (ext_f_q == held_ext_q);

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        ext_f_d      = ext_f_q;
        brk_f_d      = brk_f_q;
        evt_d        = evt_q;
        press_cnt_d  = press_cnt_q;
        held_d       = held_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        err_ovf_d    = err_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    state_d = POP;
                end
            end
            POP: begin
                // The byte is consumed even if rx_ready fell mid-pop.
                byte_d  = rx_data;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = IDLE;
                if (byte_q == SC_EXT) begin
                    ext_f_d = 1'b1;
                end else if (byte_q == SC_BREAK) begin
                    brk_f_d = 1'b1;
                end else if (is_drop_code(byte_q)) begin
                    ext_f_d = 1'b0;
                    brk_f_d = 1'b0;
                end else begin
                    ext_f_d = 1'b0;
                    brk_f_d = 1'b0;
                    if (brk_f_q) begin
                        evt_d   = '{code: byte_q, ext: ext_f_q, brk: 1'b1};
                        state_d = EMIT;
                        if (held_match) begin
                            held_d = 1'b0;
                        end
                    end else if (!(FILTER_REPEAT && held_match)) begin
                        evt_d       = '{code: byte_q, ext: ext_f_q, brk: 1'b0};
                        state_d     = EMIT;
                        held_d      = 1'b1;
                        held_code_d = byte_q;
                        held_ext_d  = ext_f_q;
                        press_cnt_d = press_cnt_q + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (evt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_clr) begin
            err_ovf_d = 1'b0;
        end
        // Overflow means bytes were lost, so any half-parsed prefix is stale.
        if (rx_overflow) begin
            err_ovf_d = 1'b1;
            ext_f_d   = 1'b0;
            brk_f_d   = 1'b0;
        end

        nextdata_n_d = (state_d != POP);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            ext_f_q      <= 1'b0;
            brk_f_q      <= 1'b0;
            evt_q        <= '0;
            nextdata_n_q <= 1'b1;
            press_cnt_q  <= '0;
            held_q       <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            ext_f_q      <= ext_f_d;
            brk_f_q      <= brk_f_d;
            evt_q        <= evt_d;
            nextdata_n_q <= nextdata_n_d;
            press_cnt_q  <= press_cnt_d;
            held_q       <= held_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign rx_nextdata_n = nextdata_n_q;
    assign evt_valid     = (state_q == EMIT);
    assign evt_code      = evt_q.code;
    assign evt_ext       = evt_q.ext;
    assign evt_break     = evt_q.brk;
    assign press_cnt     = press_cnt_q;
    assign held          = held_q;
    assign held_code     = held_code_q;
    assign held_ext      = held_ext_q;
    assign err_ovf       = err_ovf_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a byte-queue receiver model feeds two
// instances (repeat filter on/off); monitors compare accepted events.
module tb_ps2_scan_ctrl;
  import ps2_pkg::*;

  localparam int W = 11;  // {held, brk, ext, code} seen while the event is offered

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (repeat filter on) ----------------
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_overflow = 1'b0;
  logic       err_clr = 1'b0;
  logic       evt_ready = 1'b1;
  logic       rx_nextdata_n, evt_valid, evt_ext, evt_break, held, held_ext, err_ovf;
  logic [7:0] evt_code, held_code, press_cnt;
  logic [1:0] dbg_state;

  ps2_scan_ctrl #(.CNT_W(8), .FILTER_REPEAT(1'b1)) u_dut (
    .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .press_cnt(press_cnt),
    .held(held), .held_code(held_code), .held_ext(held_ext),
    .err_ovf(err_ovf), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // ---------------- DUT B (repeat filter off) ----------------
  logic [7:0] rx_data2 = 8'h00;
  logic       rx_ready2 = 1'b0;
  logic       zero_in = 1'b0;
  logic       one_in = 1'b1;
  logic       rx_nextdata_n2, evt_valid2, evt_ext2, evt_break2, held2, held_ext2, err_ovf2;
  logic [7:0] evt_code2, held_code2, press_cnt2;
  logic [1:0] dbg_state2;

  ps2_scan_ctrl #(.CNT_W(8), .FILTER_REPEAT(1'b0)) u_dut_nf (
    .clk(clk), .clrn(clrn), .rx_data(rx_data2), .rx_ready(rx_ready2),
    .rx_overflow(zero_in), .rx_nextdata_n(rx_nextdata_n2),
    .evt_valid(evt_valid2), .evt_ready(one_in), .evt_code(evt_code2),
    .evt_ext(evt_ext2), .evt_break(evt_break2), .press_cnt(press_cnt2),
    .held(held2), .held_code(held_code2), .held_ext(held_ext2),
    .err_ovf(err_ovf2), .err_clr(zero_in), .dbg_state(dbg_state2)
  );

  // ---------------- receiver FIFO models ----------------
  logic [7:0] fifo[$];
  logic [7:0] fifo2[$];
  int         pop_cnt = 0;
  int         pop_cnt2 = 0;

  always @(posedge clk) begin
    if (clrn && !rx_nextdata_n) begin
      pop_cnt++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    if (clrn && !rx_nextdata_n2) begin
      pop_cnt2++;
      if (fifo2.size() > 0) void'(fifo2.pop_front());
    end
  end

  always @(negedge clk) begin
    rx_ready  = (fifo.size() > 0);
    rx_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
    rx_ready2 = (fifo2.size() > 0);
    rx_data2  = (fifo2.size() > 0) ? fifo2[0] : 8'h00;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q2[$];
  int checks = 0;
  int errors = 0;
  int evt_cnt2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clrn && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check("evt_unexpected", {held, evt_break, evt_ext, evt_code}, 32'hFFFF_FFFF);
      else check("evt", {held, evt_break, evt_ext, evt_code}, exp_q.pop_front());
    end
    if (clrn && evt_valid2) begin
      evt_cnt2++;
      if (exp_q2.size() == 0) check("evt_nf_unexpected", {held2, evt_break2, evt_ext2, evt_code2}, 32'hFFFF_FFFF);
      else check("evt_nf", {held2, evt_break2, evt_ext2, evt_code2}, exp_q2.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk, input logic h);
    exp_q.push_back({h, brk, ext, code});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clrn = 1'b0;
    fifo.delete(); fifo2.delete(); exp_q.delete(); exp_q2.delete();
    pop_cnt = 0; pop_cnt2 = 0; evt_cnt2 = 0;
    rx_overflow = 1'b0; err_clr = 1'b0; evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (!(fifo.size() == 0 && fifo2.size() == 0 && exp_q.size() == 0 && exp_q2.size() == 0
             && dbg_state == IDLE && dbg_state2 == IDLE) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, (n >= max_cyc), 0);
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (!evt_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_timeout"}, (n >= max_cyc), 0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_nextdata_n"}, rx_nextdata_n, 1);
    check({name, "_evt_valid"}, evt_valid, 0);
    check({name, "_evt_fields"}, {evt_code, evt_ext, evt_break}, 0);
    check({name, "_press_cnt"}, press_cnt, 0);
    check({name, "_held"}, {held, held_code, held_ext}, 0);
    check({name, "_err_ovf"}, err_ovf, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    do_reset();
    @(negedge clk);
    check_reset_vals("reset");

    // make then break of a plain key
    do_reset();
    push(8'h1C); push(8'hF0); push(8'h1C);
    expect_evt(8'h1C, 0, 0, 1);
    expect_evt(8'h1C, 0, 1, 0);
    wait_drain("basic", 200);
    check("basic_pops", pop_cnt, 3);
    check("basic_press_cnt", press_cnt, 1);
    check("basic_held", {held, held_code}, {1'b0, 8'h1C});

    // extended make and extended break
    do_reset();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    expect_evt(8'h75, 1, 0, 1);
    expect_evt(8'h75, 1, 1, 0);
    wait_drain("ext", 200);
    check("ext_pops", pop_cnt, 5);
    check("ext_press_cnt", press_cnt, 1);

    // typematic repeat: filtered on DUT A, passed on DUT B
    do_reset();
    foreach (fifo[i]) ;
    begin
      logic [7:0] seq [5];
      seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
      for (int i = 0; i < 5; i++) begin
        push(seq[i]);
        fifo2.push_back(seq[i]);
      end
    end
    expect_evt(8'h1C, 0, 0, 1);
    expect_evt(8'h1C, 0, 1, 0);
    for (int i = 0; i < 3; i++) exp_q2.push_back({1'b1, 1'b0, 1'b0, 8'h1C});
    exp_q2.push_back({1'b0, 1'b1, 1'b0, 8'h1C});
    wait_drain("repeat", 300);
    check("repeat_press_cnt", press_cnt, 1);
    check("repeat_nf_events", evt_cnt2, 4);
    check("repeat_nf_press_cnt", press_cnt2, 3);

    // back-pressure: event held stable, no pops while stalled
    do_reset();
    evt_ready = 1'b0;
    push(8'h1C); push(8'h32);
    expect_evt(8'h1C, 0, 0, 1);
    expect_evt(8'h32, 0, 0, 1);
    wait_valid("stall", 50);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!evt_valid || evt_code != 8'h1C || rx_nextdata_n != 1'b1) k++;
    end
    check("stall_stable_cycles", k, 0);
    check("stall_pops", pop_cnt, 1);
    @(posedge clk); #1;
    evt_ready = 1'b1;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i > 1 && evt_valid) begin
        k = i - 1;
        break;
      end
    end
    check("stall_release_in_4", (k >= 1 && k <= 4), 1);
    wait_drain("stall", 100);
    check("stall_press_cnt", press_cnt, 2);

    // error byte drops pending prefix
    do_reset();
    push(8'hE0); push(8'h00); push(8'h1C);
    expect_evt(8'h1C, 0, 0, 1);
    wait_drain("errbyte", 100);
    check("errbyte_pops", pop_cnt, 3);
    check("errbyte_press_cnt", press_cnt, 1);

    // overflow: set beats clear, and clears a pending prefix
    do_reset();
    push(8'hE0);
    wait_drain("ovf_prefix", 100);
    @(posedge clk); #1;
    rx_overflow = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1;
    rx_overflow = 1'b0; err_clr = 1'b0;
    check("ovf_set_wins", err_ovf, 1);
    push(8'h1C);
    expect_evt(8'h1C, 0, 0, 1);
    wait_drain("ovf", 100);
    check("ovf_sticky", err_ovf, 1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("ovf_cleared", err_ovf, 0);

    // async reset while an event is being offered
    do_reset();
    evt_ready = 1'b0;
    push(8'h2A);
    wait_valid("rst_emit", 50);
    check("rst_emit_pre_cnt", press_cnt, 1);
    @(posedge clk); #3;
    clrn = 1'b0;
    fifo.delete(); exp_q.delete();
    #1;
    check_reset_vals("rst_emit");
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;

    // counter wrap after 256 presses
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'h10 + 8'(i % 64);
      push(c); push(8'hF0); push(c);
      expect_evt(c, 0, 0, 1);
      expect_evt(c, 0, 1, 0);
    end
    wait_drain("wrap", 6000);
    check("wrap_pops", pop_cnt, 768);
    check("wrap_press_cnt", press_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
